// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the memory port arbiter.
// Holds the arbiter FSM state encoding and the NOP instruction that is
// returned to fetch when a memory access is abandoned.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: counts consecutive wait cycles of an outstanding
// memory access and flags expiry on the TIMEOUT-th cycle without mem_ready.
// Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic busy_i,
    input  logic ready_i,
    output logic expired_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: restart whenever the access is not waiting, saturate at TIMEOUT.
    always_comb begin
        cnt_d = cnt_q;
        if (!busy_i || ready_i) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(TIMEOUT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Wait-cycle counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expire during the TIMEOUT-th consecutive cycle with ready low.
    assign expired_o = busy_i & ~ready_i & (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction
// fetch and data load/store, data having fixed priority. Read data is
// latched per requester until the pipeline advances; stall_mem freezes the
// pipeline while any requester is still unserved.
// Optional feature macro: MEM_ARB_TIMEOUT_EN (access watchdog + arb_err).
//
// Memory handshake: mem_valid is held high with stable mem_we/addr/wdata/be
// from the cycle after the grant until the cycle in which mem_ready=1; that
// cycle completes the access and mem_rdata is sampled on its closing edge.
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic [XLEN-1:0] if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [XLEN-1:0] d_wdata,
    input  logic [3:0]      d_be,
    output logic [XLEN-1:0] d_rdata,
    output logic            mem_valid,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            stall_mem,
    output logic            arb_err
);

    arb_state_t      state_q;
    logic            i_served_q;
    logic            d_served_q;
    logic            mem_valid_q;
    logic            mem_we_q;
    logic [AW-1:0]   mem_addr_q;
    logic [XLEN-1:0] mem_wdata_q;
    logic [3:0]      mem_be_q;
    logic [XLEN-1:0] if_rdata_q;
    logic [XLEN-1:0] d_rdata_q;
    logic            i_pend;
    logic            d_pend;
    logic            timeout_hit;

    assign i_pend    = if_req & ~i_served_q;
    assign d_pend    = d_req & ~d_served_q;
    assign stall_mem = i_pend | d_pend;

`ifdef MEM_ARB_TIMEOUT_EN
    logic arb_err_q;
    logic wd_busy;

    assign wd_busy = (state_q == BUSY_I) || (state_q == BUSY_D);

    mem_arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .busy_i   (wd_busy),
        .ready_i  (mem_ready),
        .expired_o(timeout_hit)
    );

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            arb_err_q <= 1'b0;
        end else if (timeout_hit) begin
            arb_err_q <= 1'b1;
        end
    end

    assign arb_err = arb_err_q;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT == 0);
    assign timeout_hit    = 1'b0;
    assign arb_err        = 1'b0;
`endif

    // Arbiter FSM: grant, hold the registered request, capture the response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            i_served_q  <= 1'b0;
            d_served_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            // Pipeline advance or a withdrawn request retires the served flag;
            // a completion below overrides this in the same cycle.
            if (!stall_mem || !if_req) i_served_q <= 1'b0;
            if (!stall_mem || !d_req)  d_served_q <= 1'b0;

            case (state_q)
                IDLE, RESP: begin
                    if (d_pend) begin
                        state_q     <= BUSY_D;
                        mem_valid_q <= 1'b1;
                        mem_we_q    <= d_we;
                        mem_addr_q  <= d_addr;
                        mem_wdata_q <= d_wdata;
                        mem_be_q    <= d_be;
                    end else if (i_pend) begin
                        state_q     <= BUSY_I;
                        mem_valid_q <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr;
                        mem_wdata_q <= '0;
                        mem_be_q    <= 4'hF;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BUSY_I: begin
                    if (mem_ready) begin
                        if_rdata_q  <= mem_rdata;
                        i_served_q  <= 1'b1;
                        mem_valid_q <= 1'b0;
                        state_q     <= RESP;
                    end else if (timeout_hit) begin
                        if_rdata_q  <= XLEN'(NOP_INSTR);
                        i_served_q  <= 1'b1;
                        mem_valid_q <= 1'b0;
                        state_q     <= RESP;
                    end
                end
                BUSY_D: begin
                    if (mem_ready) begin
                        if (!mem_we_q) d_rdata_q <= mem_rdata;
                        d_served_q  <= 1'b1;
                        mem_valid_q <= 1'b0;
                        state_q     <= RESP;
                    end else if (timeout_hit) begin
                        if (!mem_we_q) d_rdata_q <= '0;
                        d_served_q  <= 1'b1;
                        mem_valid_q <= 1'b0;
                        state_q     <= RESP;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: self-checking bench for mem_port_arbiter.
// A memory responder pops the expected access order from a scoreboard queue;
// directed and random scenarios check stall length, read data and reset.
// Timeout scenario is compiled only with MEM_ARB_TIMEOUT_EN defined.
module tb_mem_port_arbiter;

  localparam int XLEN       = 32;
  localparam int AW         = 32;
  localparam int TB_TIMEOUT = 8;
  localparam int TW         = 1 + 4 + AW + XLEN;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            if_req = 1'b0;
  logic [AW-1:0]   if_addr = '0;
  logic [XLEN-1:0] if_rdata;
  logic            d_req = 1'b0;
  logic            d_we = 1'b0;
  logic [AW-1:0]   d_addr = '0;
  logic [XLEN-1:0] d_wdata = '0;
  logic [3:0]      d_be = '0;
  logic [XLEN-1:0] d_rdata;
  logic            mem_valid;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_be;
  logic            mem_ready = 1'b0;
  logic [XLEN-1:0] mem_rdata = '0;
  logic            stall_mem;
  logic            arb_err;

  // scoreboard: {we, be, addr, wdata} in expected grant order
  logic [TW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            wait_states = 0;
  logic          no_ready = 1'b0;
  logic [31:0]   last_d = '0;

  mem_port_arbiter #(
    .XLEN   (XLEN),
    .AW     (AW),
    .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_be     (d_be),
    .d_rdata  (d_rdata),
    .mem_valid(mem_valid),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be   (mem_be),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .stall_mem(stall_mem),
    .arb_err  (arb_err)
  );

  // clock / global time bound
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] model_rdata(input logic [31:0] a);
    if (a == 32'h10) return 32'h0050_0093;
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // memory responder: completes after wait_states wait cycles, checks grant order
  initial begin
    int wait_cnt;
    logic [TW-1:0] e;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mem_ready = 1'b0;
        wait_cnt  = 0;
        exp_q.delete();
      end else if (mem_valid && !no_ready) begin
        if (wait_cnt >= wait_states) begin
          mem_ready = 1'b1;
          mem_rdata = model_rdata(mem_addr);
          wait_cnt  = 0;
          if (exp_q.size() == 0) begin
            check_eq("sb_extra_grant", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check_eq("sb_addr", 64'(mem_addr), 64'(e[63:32]));
            check_eq("sb_we", 64'(mem_we), 64'(e[68]));
            check_eq("sb_be", 64'(mem_be), 64'(e[67:64]));
            if (e[68]) check_eq("sb_wdata", 64'(mem_wdata), 64'(e[31:0]));
          end
        end else begin
          mem_ready = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ready = 1'b0;
        wait_cnt  = 0;
      end
    end
  end

  // driver tasks
  task automatic push_d(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
    d_req = 1'b1; d_we = we; d_be = be; d_addr = a; d_wdata = wd;
    exp_q.push_back({we, be, a, wd});
  endtask

  task automatic push_i(input logic [31:0] a);
    if_req = 1'b1; if_addr = a;
    exp_q.push_back({1'b0, 4'hF, a, 32'h0});
  endtask

  // counts stalled cycles from the current cycle, bounded
  task automatic run_until_free(output int n);
    n = 0;
    #1;
    while (stall_mem && n < 64) begin
      n++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic drop_reqs();
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    logic both, di, ii, we;
    logic [31:0] a_d, a_i, wd;
    logic [3:0] be;
    int exp_n;

    // reset
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_mem_valid", 64'(mem_valid), 64'd0);
    check_eq("rst_stall", 64'(stall_mem), 64'd0);
    check_eq("rst_outs", 64'({mem_we, mem_be, mem_addr}), 64'd0);
    check_eq("rst_rdata", 64'({if_rdata, d_rdata}), 64'd0);
    check_eq("rst_arb_err", 64'(arb_err), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 1: fetch only, zero-wait
    wait_states = 0;
    push_i(32'h10);
    #1;
    check_eq("t1_stall_c0", 64'(stall_mem), 64'd1);
    check_eq("t1_valid_c0", 64'(mem_valid), 64'd0);
    @(negedge clk); #1;
    check_eq("t1_valid_c1", 64'(mem_valid), 64'd1);
    check_eq("t1_addr_c1", 64'(mem_addr), 64'h10);
    @(negedge clk); #1;
    check_eq("t1_rdata_c2", 64'(if_rdata), 64'h0050_0093);
    check_eq("t1_stall_c2", 64'(stall_mem), 64'd0);
    check_eq("t1_valid_c2", 64'(mem_valid), 64'd0);
    drop_reqs();

    // 2: data and fetch together, data first, 4 stall cycles
    push_d(1'b0, 4'hF, 32'h200, 32'h0);
    push_i(32'h14);
    run_until_free(n);
    check_eq("t2_stall_cycles", 64'(n), 64'd4);
    check_eq("t2_d_rdata", 64'(d_rdata), 64'(model_rdata(32'h200)));
    check_eq("t2_if_rdata", 64'(if_rdata), 64'(model_rdata(32'h14)));
    last_d = model_rdata(32'h200);
    drop_reqs();

    // 3: store, be=0011, 3 wait states, request inputs change while busy
    wait_states = 3;
    push_d(1'b1, 4'b0011, 32'h300, 32'hDEAD_BEEF);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      #1;
      check_eq("t3_hold_valid", 64'(mem_valid), 64'd1);
      check_eq("t3_hold_we_be", 64'({mem_we, mem_be}), 64'({1'b1, 4'b0011}));
      check_eq("t3_hold_addr", 64'(mem_addr), 64'h300);
      check_eq("t3_hold_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
      if (k == 1) begin d_addr = 32'h7FC; d_wdata = 32'h1234_5678; d_be = 4'hF; end
      @(negedge clk);
    end
    #1;
    check_eq("t3_stall_done", 64'(stall_mem), 64'd0);
    check_eq("t3_d_rdata_kept", 64'(d_rdata), 64'(last_d));
    drop_reqs();

    // 4: reset while BUSY_D
    wait_states = 5;
    push_d(1'b0, 4'hF, 32'h400, 32'h0);
    @(negedge clk); #1;
    check_eq("t4_busy_valid", 64'(mem_valid), 64'd1);
    rst = 1'b0; d_req = 1'b0;
    #1;
    check_eq("t4_stall_low", 64'(stall_mem), 64'd0);
    @(negedge clk); #1;
    check_eq("t4_mem_valid", 64'(mem_valid), 64'd0);
    check_eq("t4_outs", 64'({mem_we, mem_be, mem_addr}), 64'd0);
    check_eq("t4_wdata", 64'(mem_wdata), 64'd0);
    check_eq("t4_rdata", 64'({if_rdata, d_rdata}), 64'd0);
    check_eq("t4_arb_err", 64'(arb_err), 64'd0);
    last_d = '0;
    rst = 1'b1;
    @(negedge clk);

    // 5: back-to-back fetch across an advance
    wait_states = 0;
    push_i(32'h20);
    run_until_free(n);
    check_eq("t5_first_stall", 64'(n), 64'd2);
    push_i(32'h24);
    #1;
    check_eq("t5_adv_stall", 64'(stall_mem), 64'd0);
    @(negedge clk); #1;
    check_eq("t5_new_stall", 64'(stall_mem), 64'd1);
    check_eq("t5_no_early_grant", 64'(mem_valid), 64'd0);
    @(negedge clk); #1;
    check_eq("t5_grant_valid", 64'(mem_valid), 64'd1);
    check_eq("t5_grant_addr", 64'(mem_addr), 64'h24);
    @(negedge clk); #1;
    check_eq("t5_rdata", 64'(if_rdata), 64'(model_rdata(32'h24)));
    check_eq("t5_stall_done", 64'(stall_mem), 64'd0);
    drop_reqs();

    // random mixes
    for (int it = 0; it < 12; it++) begin
      wait_states = $urandom_range(0, 3);
      di = 1'($urandom_range(0, 1));
      ii = 1'($urandom_range(0, 1));
      if (!di && !ii) ii = 1'b1;
      we   = 1'($urandom_range(0, 1));
      be   = 4'($urandom_range(1, 15));
      a_d  = {22'h0, 8'($urandom_range(0, 255)), 2'b00} | 32'h1000;
      a_i  = {22'h0, 8'($urandom_range(0, 255)), 2'b00} | 32'h2000;
      wd   = $urandom;
      both = di & ii;
      if (di) push_d(we, be, a_d, wd);
      if (ii) push_i(a_i);
      exp_n = both ? (2 * wait_states + 4) : (wait_states + 2);
      run_until_free(n);
      check_eq("rnd_stall_cycles", 64'(n), 64'(exp_n));
      if (di) begin
        if (!we) last_d = model_rdata(a_d);
        check_eq("rnd_d_rdata", 64'(d_rdata), 64'(last_d));
      end
      if (ii) check_eq("rnd_if_rdata", 64'(if_rdata), 64'(model_rdata(a_i)));
      drop_reqs();
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // 6: fetch with memory never ready
    no_ready = 1'b1;
    if_req = 1'b1; if_addr = 32'h30;
    run_until_free(n);
    check_eq("t6_stall_cycles", 64'(n), 64'(TB_TIMEOUT + 1));
    check_eq("t6_arb_err", 64'(arb_err), 64'd1);
    check_eq("t6_nop", 64'(if_rdata), 64'h13);
    check_eq("t6_valid_drop", 64'(mem_valid), 64'd0);
    drop_reqs();
    no_ready = 1'b0;
    @(negedge clk); #1;
    check_eq("t6_err_sticky", 64'(arb_err), 64'd1);
`else
    #1;
    check_eq("arb_err_tied", 64'(arb_err), 64'd0);
`endif

    repeat (2) @(negedge clk);
    check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
